// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_arbiter
// Description : Arbitrates icache/dcache word requests onto one byte-serial
//               memory unit, one transaction at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              ic_valid,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_done,
  output logic [DATA_W-1:0] ic_data,
  input  logic              dc_valid,
  input  logic              dc_rw,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_done,
  output logic [DATA_W-1:0] dc_data,
  input  logic              flush,
  output logic              mem_valid,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IC = 2'd1, OWN_DC = 2'd2} owner_t;

  localparam logic [3:0] c_STARVE_LIM = 4'(STARVE_LIMIT);
  localparam logic [3:0] c_STARVE_MAX = 4'hF;

  state_t            r_state;
  owner_t            r_owner;
  logic [3:0]        r_starve_cnt;
  logic              r_drop;
  logic              r_mem_valid;
  logic              r_mem_rw;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_ic_done;
  logic [DATA_W-1:0] r_ic_data;
  logic              r_dc_done;
  logic [DATA_W-1:0] r_dc_data;

  logic w_ic_elig;
  logic w_grant_ic;
  logic w_grant_dc;
  logic w_drop_now;

  // dcache wins by default; icache is forced through once it has lost too often.
  always_comb begin
    w_ic_elig  = ic_valid & ~flush;
    w_grant_ic = w_ic_elig & (~dc_valid | (r_starve_cnt >= c_STARVE_LIM));
    w_grant_dc = dc_valid & ~w_grant_ic;
    w_drop_now = r_drop | flush;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_NONE;
      r_starve_cnt <= 4'd0;
      r_drop       <= 1'b0;
      r_mem_valid  <= 1'b0;
      r_mem_rw     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_ic_done    <= 1'b0;
      r_ic_data    <= '0;
      r_dc_done    <= 1'b0;
      r_dc_data    <= '0;
    end else if (rdy) begin
      r_ic_done <= 1'b0;
      r_dc_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_ic) begin
            r_state      <= ST_BUSY;
            r_owner      <= OWN_IC;
            r_starve_cnt <= 4'd0;
            r_drop       <= 1'b0;
            r_mem_valid  <= 1'b1;
            r_mem_rw     <= 1'b0;
            r_mem_addr   <= ic_addr;
            r_mem_wdata  <= '0;
          end else if (w_grant_dc) begin
            r_state     <= ST_BUSY;
            r_owner     <= OWN_DC;
            r_drop      <= 1'b0;
            r_mem_valid <= 1'b1;
            r_mem_rw    <= dc_rw;
            r_mem_addr  <= dc_addr;
            r_mem_wdata <= dc_wdata;
            if (w_ic_elig && (r_starve_cnt != c_STARVE_MAX)) begin
              r_starve_cnt <= r_starve_cnt + 4'd1;
            end
          end
        end
        ST_BUSY: begin
          if (flush && (r_owner == OWN_IC)) begin
            r_drop <= 1'b1;
          end
          if (mem_done) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_NONE;
            r_mem_valid <= 1'b0;
            r_drop      <= 1'b0;
            if (r_owner == OWN_DC) begin
              r_dc_done <= 1'b1;
              r_dc_data <= r_mem_rw ? '0 : mem_rdata;
            end else if ((r_owner == OWN_IC) && !w_drop_now) begin
              r_ic_done <= 1'b1;
              r_ic_data <= mem_rdata;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_valid = r_mem_valid;
  assign mem_rw    = r_mem_rw;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign ic_done   = r_ic_done;
  assign ic_data   = r_ic_data;
  assign dc_done   = r_dc_done;
  assign dc_data   = r_dc_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_req_arbiter
// Description : Directed scoreboard bench for mem_req_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        ic_valid = 1'b0;
  logic [31:0] ic_addr = '0;
  logic        ic_done;
  logic [31:0] ic_data;
  logic        dc_valid = 1'b0;
  logic        dc_rw = 1'b0;
  logic [31:0] dc_addr = '0;
  logic [31:0] dc_wdata = '0;
  logic        dc_done;
  logic [31:0] dc_data;
  logic        flush = 1'b0;
  logic        mem_valid;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done = 1'b0;
  logic [31:0] mem_rdata = '0;

  mem_req_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ic_valid(ic_valid), .ic_addr(ic_addr), .ic_done(ic_done), .ic_data(ic_data),
    .dc_valid(dc_valid), .dc_rw(dc_rw), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_done(dc_done), .dc_data(dc_data), .flush(flush),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic dc; logic [31:0] data; } done_t;
  typedef struct packed { logic rw; logic [31:0] addr; logic [31:0] wdata; } req_t;

  done_t done_q[$];
  req_t  req_q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_req(input logic rw, input logic [31:0] a, input logic [31:0] wd);
    req_q.push_back('{rw: rw, addr: a, wdata: wd});
  endtask

  task automatic exp_done(input logic is_dc, input logic [31:0] d);
    done_q.push_back('{dc: is_dc, data: d});
  endtask

  // Memory side: wait lat cycles, then a one-cycle mem_done with rdata.
  task automatic serve(input int lat, input logic [31:0] rdata);
    repeat (lat) tick();
    mem_done  = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_done  = 1'b0;
  endtask

  // Scoreboard monitor: compares every presented request and done pulse.
  initial begin
    done_t d;
    req_t  r;
    logic  prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (ic_done && dc_done) chk("both_done", 32'(ic_done & dc_done), 32'd0);
      if (ic_done || dc_done) begin
        if (done_q.size() == 0) begin
          chk("spurious_done", {30'd0, ic_done, dc_done}, 32'd0);
        end else begin
          d = done_q.pop_front();
          chk("done_owner", 32'(dc_done), 32'(d.dc));
          chk("done_data", dc_done ? dc_data : ic_data, d.data);
        end
      end
      if (mem_valid && !prev_v) begin
        if (req_q.size() == 0) begin
          chk("spurious_mem_valid", 32'(mem_valid), 32'd0);
        end else begin
          r = req_q.pop_front();
          chk("mem_rw", 32'(mem_rw), 32'(r.rw));
          chk("mem_addr", mem_addr, r.addr);
          chk("mem_wdata", mem_wdata, r.wdata);
        end
      end
      prev_v = mem_valid;
    end
  end

  // Four dcache wins while icache waits, then the forced icache grant.
  task automatic starve_round(input logic [31:0] base);
    ic_valid = 1'b1;
    ic_addr  = base + 32'h800;
    for (int k = 0; k < 4; k++) begin
      dc_valid = 1'b1;
      dc_rw    = 1'b0;
      dc_addr  = base + 32'(4 * k);
      exp_req(1'b0, dc_addr, 32'd0);
      exp_done(1'b1, base ^ 32'(k));
      tick();
      chk("starve_dc_grant_rw", 32'(mem_valid & ~mem_rw), 32'd1);
      serve(1, base ^ 32'(k));
    end
    dc_addr = base + 32'h100;
    exp_req(1'b0, base + 32'h800, 32'd0);
    exp_done(1'b0, 32'h4444_0000 | base[15:0]);
    tick();
    chk("starve_ic_forced", mem_addr, base + 32'h800);
    serve(1, 32'h4444_0000 | base[15:0]);
    chk("starve_ic_done", 32'(ic_done), 32'd1);
  endtask

  initial begin
    // Reset
    rst = 1'b0;
    tick(); tick();
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_dones", {30'd0, ic_done, dc_done}, 32'd0);
    rst = 1'b1;
    tick();

    // Single icache read, 4-cycle memory latency
    ic_valid = 1'b1; ic_addr = 32'h1000;
    exp_req(1'b0, 32'h1000, 32'd0);
    exp_done(1'b0, 32'hDEAD_BEEF);
    tick();
    chk("ic_latency", 32'(mem_valid), 32'd1);
    serve(3, 32'hDEAD_BEEF);
    chk("ic_done_pulse", 32'(ic_done), 32'd1);
    chk("ic_mem_valid_clr", 32'(mem_valid), 32'd0);
    ic_valid = 1'b0;
    tick();
    chk("ic_done_one_cycle", 32'(ic_done), 32'd0);
    chk("ic_data_hold", ic_data, 32'hDEAD_BEEF);

    // Simultaneous icache read and dcache write: dcache first
    ic_valid = 1'b1; ic_addr = 32'h3000;
    dc_valid = 1'b1; dc_rw = 1'b1; dc_addr = 32'h2004; dc_wdata = 32'h1234_5678;
    exp_req(1'b1, 32'h2004, 32'h1234_5678);
    exp_done(1'b1, 32'd0);
    exp_req(1'b0, 32'h3000, 32'd0);
    exp_done(1'b0, 32'h0BAD_C0DE);
    tick();
    serve(2, 32'hCAFE_F00D);
    chk("dc_wr_done", 32'(dc_done), 32'd1);
    dc_valid = 1'b0; dc_rw = 1'b0; dc_wdata = '0;
    tick();
    chk("ic_after_idle", 32'(mem_valid), 32'd1);
    serve(1, 32'h0BAD_C0DE);
    ic_valid = 1'b0;
    tick();

    // Starvation override, twice to show the counter restarts from zero
    starve_round(32'h5000);
    starve_round(32'h6000);
    ic_valid = 1'b0;
    dc_valid = 1'b0;
    tick();

    // Flush in IDLE blocks icache; flush in BUSY drops its completion
    ic_valid = 1'b1; ic_addr = 32'h7000; flush = 1'b1;
    tick();
    chk("flush_idle_no_grant", 32'(mem_valid), 32'd0);
    flush = 1'b0;
    exp_req(1'b0, 32'h7000, 32'd0);
    tick();
    tick();
    flush = 1'b1; ic_valid = 1'b0;
    tick();
    flush = 1'b0;
    serve(1, 32'hAAAA_5555);
    chk("flush_no_ic_done", 32'(ic_done), 32'd0);
    chk("flush_idle", 32'(mem_valid), 32'd0);
    tick();
    ic_valid = 1'b1; ic_addr = 32'h7004;
    exp_req(1'b0, 32'h7004, 32'd0);
    exp_done(1'b0, 32'h1357_2468);
    tick();
    serve(2, 32'h1357_2468);
    chk("post_flush_ic_done", 32'(ic_done), 32'd1);
    ic_valid = 1'b0;
    tick();

    // Reset mid dcache read; late mem_done ignored
    dc_valid = 1'b1; dc_rw = 1'b0; dc_addr = 32'h8000;
    exp_req(1'b0, 32'h8000, 32'd0);
    tick();
    tick();
    rst = 1'b0; dc_valid = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_mem_valid", 32'(mem_valid), 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_ic_data", ic_data, 32'd0);
    chk("midrst_dc_data", dc_data, 32'd0);
    serve(0, 32'h9999_9999);
    chk("midrst_no_dc_done", 32'(dc_done), 32'd0);
    tick();
    dc_valid = 1'b1; dc_addr = 32'h8004;
    exp_req(1'b0, 32'h8004, 32'd0);
    exp_done(1'b1, 32'h2468_ACE0);
    tick();
    serve(1, 32'h2468_ACE0);
    dc_valid = 1'b0;
    tick();

    // rdy low mid-BUSY freezes everything
    ic_valid = 1'b1; ic_addr = 32'h9000;
    exp_req(1'b0, 32'h9000, 32'd0);
    exp_done(1'b0, 32'h55AA_55AA);
    tick();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_mem_valid", 32'(mem_valid), 32'd1);
      chk("stall_mem_addr", mem_addr, 32'h9000);
    end
    rdy = 1'b1;
    serve(1, 32'h55AA_55AA);
    chk("stall_ic_done", 32'(ic_done), 32'd1);
    ic_valid = 1'b0;
    tick(); tick();

    chk("done_q_empty", 32'(done_q.size()), 32'd0);
    chk("req_q_empty", 32'(req_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Sits between the instruction cache, the data cache and the single byte-serial memory unit.
- Arbitrates 32-bit word requests and issues exactly one transaction at a time downstream.
- Routes the completion pulse and read data back to the owning requester.
- Default priority goes to dcache; icache gets an anti-starvation override; a pipeline flush kills icache traffic.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, word width
STARVE_LIMIT, 4, consecutive dcache wins while icache waits before icache is forced through (1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
rdy  in  1  global enable; when 0 all state and outputs hold
ic_valid  in  1  icache read request, held until ic_done
ic_addr  in  ADDR_W  icache word address
ic_done  out  1  one-cycle completion pulse to icache
ic_data  out  DATA_W  read data, valid with ic_done
dc_valid  in  1  dcache request, held until dc_done
dc_rw  in  1  1=write, 0=read
dc_addr  in  ADDR_W  dcache word address
dc_wdata  in  DATA_W  store data
dc_done  out  1  one-cycle completion pulse to dcache
dc_data  out  DATA_W  load data, valid with dc_done (0 for writes)
flush  in  1  branch mispredict; cancels icache traffic
mem_valid  out  1  request to memory unit, held until mem_done
mem_rw  out  1  transaction direction
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched store data
mem_done  in  1  one-cycle completion from memory unit
mem_rdata  in  DATA_W  read data, valid with mem_done

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE, owner=NONE, starve_cnt=0, drop=0.
  - All outputs 0: mem_valid, mem_rw, mem_addr, mem_wdata, ic_done, ic_data, dc_done, dc_data.
  - Reset mid-transaction abandons it; any later mem_done is ignored because state is IDLE.
- rdy=0: no register changes; mem_done arriving while rdy=0 is lost (memory unit shares rdy).
- States:
  - IDLE: evaluate requests each cycle.
  - BUSY: transaction outstanding.
  - Done pulses are registered outputs generated on the BUSY->IDLE transition.
- IDLE grant rules, first match wins:
  1. flush=1: icache ineligible this cycle.
  2. ic eligible, dc_valid, and starve_cnt>=STARVE_LIMIT: grant icache.
  3. dc_valid: grant dcache. Increment starve_cnt (saturating at 15) if ic_valid & !flush.
  4. ic eligible: grant icache.
  5. Otherwise remain IDLE.
- Any icache grant clears starve_cnt to 0.
- On grant:
  - Next cycle mem_valid=1; owner, mem_rw, mem_addr, mem_wdata latched (mem_rw=0 and mem_wdata=0 for icache).
  - State -> BUSY. Latency is 1 cycle from request seen to mem_valid.
- BUSY:
  - mem_* held stable; new requests are ignored.
  - On mem_done: mem_valid cleared next cycle, state -> IDLE.
  - owner=DC: dc_done=1 for exactly one cycle; dc_data=mem_rdata for reads, 0 for writes.
  - owner=IC and drop=0: ic_done=1, ic_data=mem_rdata.
  - owner=IC and drop=1: no pulse, drop cleared.
- flush while BUSY with owner=IC: drop set; the transaction still completes (memory unit cannot abort).
- flush with owner=DC or in IDLE: only suppresses icache eligibility; no effect on dcache.
- Back-to-back: the IDLE cycle after completion is mandatory. The requester must see its done pulse and drop valid, so the minimum turnaround is 1 idle cycle between mem_done and the next mem_valid.
- mem_done in IDLE: ignored, no pulse.
- ic_done and dc_done are never high in the same cycle.
- ic_data and dc_data hold their last value between pulses.

Test Plan:
- Reset then ic_valid=1, ic_addr=0x1000, mem_done 4 cycles after mem_valid with mem_rdata=0xDEADBEEF -> mem_valid=1 next cycle, mem_addr=0x1000, mem_rw=0; ic_done pulses one cycle with ic_data=0xDEADBEEF; dc_done stays 0.
- ic_valid and dc_valid (write, addr 0x2004, wdata 0x12345678) rise the same cycle -> dcache granted first with mem_rw=1 and mem_wdata=0x12345678; dc_done with dc_data=0; icache granted after the idle cycle.
- STARVE_LIMIT=4: dc_valid re-asserted immediately after every dc_done while ic_valid is held -> exactly 4 dcache grants, then an icache grant, then starve_cnt=0.
- Icache transaction in BUSY, flush pulsed 1 cycle, then mem_done with rdata 0xAAAA5555 -> no ic_done pulse; state IDLE; a subsequent ic_valid is served normally with ic_done.
- Dcache read in flight, rst=0 for 1 cycle, then mem_done -> all outputs 0; no dc_done; arbiter IDLE and accepts a fresh request.
- rdy=0 for 3 cycles mid-BUSY with mem_done withheld -> mem_valid and mem_addr unchanged; completion proceeds normally once rdy=1 and mem_done arrives.
